// File: rtl/sentinel_lock_ctrl.sv
// ---------------------------------------------------------------------------
// sentinel_lock_ctrl
//
// Sequencing controller for the Sentinel key-compare datapath. A rising edge
// on submit captures the DIP-switch key. The key must then stay stable for a
// debounce window, after which it is evaluated exactly once:
//   - a match gives a timed unlock hold;
//   - a mismatch counts as a failed attempt, and MAX_FAILS consecutive
//     failures give a timed lockout.
// The 7-segment display and the status array are decoded from the registered
// state.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset; overrides ena
//   ena        - power-state enable; 0 freezes the FSM and blanks the outputs
//   key_in     - 8-bit DIP-switch key
//   submit     - evaluation request (level); only its rising edge is used
//   seg_out    - {dp,g,f,e,d,c,b,a}, active-low segment drive
//   status_out - status array (0xFF while unlocked, else flags + fail count)
//   fail_cnt   - consecutive failed attempts (not gated by ena)
//
// Request semantics: submit has no ready/ack. A request is the cycle in which
// submit is sampled high after being sampled low. It is accepted only in
// LOCKED with ena=1. In every other case (other states, or ena=0) the request
// is dropped and is not queued.
// ---------------------------------------------------------------------------
module sentinel_lock_ctrl #(
   parameter logic [7:0] KEY                = 8'hB6,
   parameter int         DEBOUNCE_CYCLES    = 4,
   parameter int         MAX_FAILS          = 3,
   parameter int         LOCKOUT_CYCLES     = 16,
   parameter int         UNLOCK_HOLD_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] key_in,
   input  logic       submit,
   output logic [7:0] seg_out,
   output logic [7:0] status_out,
   output logic [1:0] fail_cnt
);

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_UNLOCKED = 2'd2,
      S_LOCKOUT  = 2'd3
   } state_t;

   // One counter is shared by all timed states, so it is sized for the
   // longest window.
   localparam int MAX_AB  = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ?
                            DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
   localparam int CNT_MAX = (MAX_AB > UNLOCK_HOLD_CYCLES) ?
                            MAX_AB : UNLOCK_HOLD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(UNLOCK_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]       FAIL_LIM  = 3'(MAX_FAILS);

   state_t           state;   // FSM state, kept as a named signal for debug
   logic [CNT_W-1:0] cnt;
   logic [7:0]       key_q;
   logic             submit_q;
   logic             sub_edge;

   assign sub_edge = submit & ~submit_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_LOCKED;
         cnt      <= '0;
         key_q    <= '0;
         fail_cnt <= '0;
         submit_q <= 1'b0;
      end else begin
         // The edge detector keeps running while disabled, so a submit edge
         // that occurs during ena=0 is consumed and lost.
         submit_q <= submit;
         if (ena) begin
            case (state)
               S_LOCKED: begin
                  if (sub_edge) begin
                     state <= S_DEBOUNCE;
                     key_q <= key_in;
                     cnt   <= '0;
                  end
               end

               S_DEBOUNCE: begin
                  // A key change wins over debounce completion.
                  if (key_in != key_q) begin
                     key_q <= key_in;
                     cnt   <= '0;
                  end else if (cnt != DEB_LAST) begin
                     cnt <= cnt + 1'b1;
                  end else if (key_q == KEY) begin
                     state    <= S_UNLOCKED;
                     fail_cnt <= '0;
                     cnt      <= '0;
                  end else if (({1'b0, fail_cnt} + 3'd1) == FAIL_LIM) begin
                     state    <= S_LOCKOUT;
                     fail_cnt <= 2'(MAX_FAILS);
                     cnt      <= '0;
                  end else begin
                     state    <= S_LOCKED;
                     fail_cnt <= fail_cnt + 2'd1;
                  end
               end

               S_UNLOCKED: begin
                  // Moving the switches away from the key relocks at once.
                  // This takes priority over the hold timer.
                  if (key_in != KEY) begin
                     state <= S_LOCKED;
                  end else if (cnt == HOLD_LAST) begin
                     state <= S_LOCKED;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               S_LOCKOUT: begin
                  if (cnt == LOCK_LAST) begin
                     state    <= S_LOCKED;
                     fail_cnt <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               default: state <= S_LOCKED;
            endcase
         end
      end
   end

   // Output decode of the registered state, gated by ena, with no added delay.
   always_comb begin
      seg_out    = 8'hFF;
      status_out = 8'h00;
      if (ena) begin
         case (state)
            S_LOCKED:   seg_out = 8'hC7;
            S_DEBOUNCE: seg_out = 8'hBF;
            S_UNLOCKED: seg_out = 8'hC1;
            S_LOCKOUT:  seg_out = 8'h86;
            default:    seg_out = 8'hFF;
         endcase
         if (state == S_UNLOCKED) begin
            status_out = 8'hFF;
         end else begin
            status_out = {3'b000, state == S_LOCKOUT, state == S_DEBOUNCE,
                          1'b0, fail_cnt};
         end
      end
   end

endmodule

// File: tb/tb_sentinel_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sentinel_lock_ctrl
//
// Directed scenarios followed by a randomized phase. Both are checked every
// cycle against a behavioural model. The model keeps a timestamp in
// "enabled time" and measures how much time has elapsed since the last
// event. It does not use a step counter.
// ---------------------------------------------------------------------------
module tb_sentinel_lock_ctrl;

   localparam logic [7:0] KEY   = 8'hB6;
   localparam int         DEB   = 4;
   localparam int         MAXF  = 3;
   localparam int         LOCKT = 16;
   localparam int         HOLD  = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] key_in;
   logic       submit;
   logic [7:0] seg_out;
   logic [7:0] status_out;
   logic [1:0] fail_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [17:0] exp_q[$];

   sentinel_lock_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .key_in     (key_in),
      .submit     (submit),
      .seg_out    (seg_out),
      .status_out (status_out),
      .fail_cnt   (fail_cnt)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // mode: 0 locked, 1 checking key, 2 open, 3 locked out
   int         m_mode   = 0;
   int         m_fails  = 0;
   int         m_now    = 0;  // count of enabled edges
   int         m_since  = 0;  // enabled time of the last event
   logic [7:0] m_key    = '0;
   logic       m_sub_pr = 1'b0;

   task automatic model_edge();
      logic edge_seen;
      if (!rst_n) begin
         m_mode   = 0;
         m_fails  = 0;
         m_key    = '0;
         m_sub_pr = 1'b0;
         return;
      end
      edge_seen = submit && !m_sub_pr;
      m_sub_pr  = submit;
      if (!ena) return;
      m_now++;
      case (m_mode)
         0: if (edge_seen) begin
               m_mode  = 1;
               m_key   = key_in;
               m_since = m_now;
            end
         1: if (key_in != m_key) begin
               m_key   = key_in;
               m_since = m_now;
            end else if (m_now - m_since == DEB) begin
               if (m_key == KEY) begin
                  m_mode  = 2;
                  m_fails = 0;
                  m_since = m_now;
               end else if (m_fails + 1 == MAXF) begin
                  m_mode  = 3;
                  m_fails = MAXF;
                  m_since = m_now;
               end else begin
                  m_fails++;
                  m_mode = 0;
               end
            end
         2: if (key_in != KEY || m_now - m_since == HOLD) m_mode = 0;
         3: if (m_now - m_since == LOCKT) begin
               m_mode  = 0;
               m_fails = 0;
            end
         default: m_mode = 0;
      endcase
   endtask

   function automatic logic [17:0] model_outputs();
      logic [7:0] s;
      logic [7:0] st;
      if (!ena) begin
         s  = 8'hFF;
         st = 8'h00;
      end else begin
         case (m_mode)
            0:       s = 8'hC7;
            1:       s = 8'hBF;
            2:       s = 8'hC1;
            default: s = 8'h86;
         endcase
         if (m_mode == 2) st = 8'hFF;
         else st = {3'b000, m_mode == 3, m_mode == 1, 1'b0, 2'(m_fails)};
      end
      return {s, st, 2'(m_fails)};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %02h expected %02h", tag, cyc, obs, exp);
      end
   endtask

   // One clock edge. The model advances on the same edge, and the outputs are
   // checked 1ns after it.
   task automatic tick();
      logic [17:0] e;
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_outputs());
      #1;
      cyc++;
      e = exp_q.pop_front();
      check("seg", seg_out, e[17:10]);
      check("status", status_out, e[9:2]);
      check("fail_cnt", {6'b0, fail_cnt}, {6'b0, e[1:0]});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pulse submit for one edge with the given key, then release it.
   task automatic press(input logic [7:0] k);
      key_in = k;
      submit = 1'b1;
      tick();
      submit = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      key_in = KEY;
      submit = 1'b0;
      tick();
      check("reset_seg", seg_out, 8'hC7);
      check("reset_status", status_out, 8'h00);
      rst_n = 1'b1;
      ticks(10);
      check("idle_seg", seg_out, 8'hC7);

      // Correct key: debounce, then unlock, then the hold expires.
      press(KEY);
      check("deb_seg", seg_out, 8'hBF);
      ticks(3);
      check("deb_end_seg", seg_out, 8'hBF);
      tick();
      check("unlock_seg", seg_out, 8'hC1);
      check("unlock_status", status_out, 8'hFF);
      ticks(HOLD - 1);
      check("hold_last_seg", seg_out, 8'hC1);
      tick();
      check("hold_expire_seg", seg_out, 8'hC7);

      // Three wrong keys give a lockout. A submit during lockout is ignored.
      press(8'h00); ticks(DEB);
      check("fail1", {6'b0, fail_cnt}, 8'd1);
      ticks(2);
      press(8'h00); ticks(DEB);
      check("fail2", {6'b0, fail_cnt}, 8'd2);
      ticks(2);
      press(8'h00); ticks(DEB);
      check("lockout_seg", seg_out, 8'h86);
      check("lockout_status", status_out, 8'h13);
      press(KEY);
      ticks(LOCKT - 2);
      check("lockout_hold_seg", seg_out, 8'h86);
      tick();
      check("lockout_end_seg", seg_out, 8'hC7);
      check("lockout_end_fail", {6'b0, fail_cnt}, 8'd0);
      ticks(2);

      // A key bounce restarts the debounce window.
      press(8'hB7);
      tick();
      key_in = KEY;
      tick();
      check("bounce_seg", seg_out, 8'hBF);
      ticks(3);
      check("bounce_wait_seg", seg_out, 8'hBF);
      tick();
      check("bounce_unlock_seg", seg_out, 8'hC1);
      check("bounce_fail", {6'b0, fail_cnt}, 8'd0);

      // Relock when the key is moved while unlocked.
      ticks(2);
      key_in = 8'hB4;
      tick();
      check("relock_seg", seg_out, 8'hC7);
      check("relock_status", status_out, 8'h00);
      ticks(2);

      // Disabling during debounce freezes the FSM and blanks the outputs.
      press(KEY);
      tick();
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ena_off_seg", seg_out, 8'hFF);
         check("ena_off_status", status_out, 8'h00);
      end
      ena = 1'b1;
      ticks(2);
      check("ena_resume_seg", seg_out, 8'hBF);
      tick();
      check("ena_resume_unlock", seg_out, 8'hC1);
      key_in = 8'h00;
      ticks(2);

      // Reset while locked out.
      for (int j = 0; j < MAXF; j++) begin
         press(8'h00); ticks(DEB + 1);
      end
      check("pre_rst_seg", seg_out, 8'h86);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_lockout_seg", seg_out, 8'hC7);
      check("rst_lockout_fail", {6'b0, fail_cnt}, 8'd0);

      // Randomized phase against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 8) begin
            case ($urandom_range(0, 3))
               0, 1:    key_in = KEY;
               2:       key_in = 8'h00;
               default: key_in = 8'($urandom_range(0, 255));
            endcase
         end
         submit = ($urandom_range(0, 3) == 0);
         ena    = ($urandom_range(0, 19) != 0);
         rst_n  = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
